request_unit_mc: RTL and testbench
==================================

// Module: request_unit_mc
// PURPOSE
//  Parametrised multi-channel successor to the single-channel request unit. Sits between the
//  datapath and the memory controller. Latches up to NDCH data-memory requests on each
//  instruction hit and serialises them onto the single data-memory port using round-robin
//  order. Stalls the PC until all of them complete. Adds halt draining and a watchdog timeout.
// PARAMETERS
//  NDCH       2    number of data request channels (1..8)
//  TIMEOUT    64   cycles a granted request may wait for dhit before timeout_err; 0 = disabled
//  TO_W       8    watchdog counter width; must hold TIMEOUT
// PORTS
//  CLK        in   1           clock; all state updates on rising edge
//  RST        in   1           synchronous, active-high reset
//  iREN       in   1           datapath wants an instruction fetch
//  dREN       in   NDCH        per-channel data read request (valid while ihit)
//  dWEN       in   NDCH        per-channel data write request (valid while ihit)
//  ihit       in   1           instruction fetch complete (capture strobe)
//  dhit       in   1           current data access complete
//  halt       in   1           datapath halt (level)
//  imemREN    out  1           instruction read request to memory
//  dmemREN    out  1           data read request to memory
//  dmemWEN    out  1           data write request to memory
//  dsel       out  $clog2(NDCH) (min 1)  channel currently granted the data port
//  pc_wait    out  1           hold PC: data work outstanding
//  halted     out  1           all work drained after halt; sticky
//  timeout_err out 1           watchdog fired; sticky until RST
// BEHAVIOUR
//  - Reset (RST high at an edge): pend=0, wr=0, gnt_v=0, gnt_idx=0, rr_ptr=0, state=RUN, wdog=0,
//    timeout_err=0. Outputs during and after reset: dmemREN=dmemWEN=pc_wait=halted=0, dsel=0.
//    imemREN follows its RUN-state rule below, so it equals iREN the cycle after reset.
//    RST mid-transaction abandons all pending requests. No dhit is owed afterwards.
//  - Capture: at an edge with ihit=1, state=RUN, and no pending requests (pend==0, gnt_v=0):
//    pend[k] <= dREN[k]|dWEN[k] and wr[k] <= dWEN[k].
//    dREN & dWEN both set on the same channel: the write wins.
//    ihit while work is outstanding is ignored.
//  - Arbiter: when gnt_v=0 and pend!=0, pick the first set pend bit at or after rr_ptr,
//    wrapping modulo NDCH. At the next edge, gnt_v<=1 and gnt_idx<=winner.
//    Latency: exactly one bubble cycle between capture and the first dmemREN/dmemWEN.
//  - Grant outputs: dmemREN = gnt_v & ~wr[gnt_idx]; dmemWEN = gnt_v & wr[gnt_idx];
//    dsel = gnt_idx. Outputs are held stable until dhit.
//  - On an edge with dhit & gnt_v: clear pend[gnt_idx]; gnt_v<=0; rr_ptr <= gnt_idx+1 (mod NDCH).
//    The next grant follows one cycle later.
//    dhit with gnt_v=0 is ignored.
//  - pc_wait = (pend!=0) | gnt_v. It is combinational from registers and deasserts in the cycle
//    after the final dhit.
//  - imemREN = iREN & (state==RUN) & ~pc_wait. It never overlaps dmemREN/dmemWEN.
//  - FSM states (ru_state_t): RUN, DRAIN, HALTED.
//    RUN -> HALTED on halt when pend==0 and gnt_v=0.
//    RUN -> DRAIN on halt otherwise.
//    DRAIN -> HALTED once pend==0 and gnt_v=0. DRAIN accepts no captures.
//    HALTED is sticky until RST.
//    halt and ihit on the same edge: halt wins and no capture occurs.
//  - Watchdog: wdog clears on a new grant or on dhit. It increments each cycle that gnt_v=1
//    without dhit, saturating at TIMEOUT. Reaching TIMEOUT (nonzero) sets timeout_err.
//    The request keeps being held; the watchdog does not abort it.
// STRUCTURE
//  - cpu_types_pkg: typedef enum logic [1:0] {RUN, DRAIN, HALTED} ru_state_t;
//    add localparam RU_MAX_CH = 8.
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs gnt_idx and any.
//    Purely combinational, reusable by the future cache arbiter.
//  - Modports: ru (the ports above) and tb (the mirror image).
// TESTING
//  1. RST for 2 cycles, then iREN=1 -> imemREN=1, pc_wait=0, dmemREN=dmemWEN=0, halted=0.
//  2. NDCH=2: ihit with dREN=2'b11. Expect a one-cycle bubble, then dmemREN with dsel=0.
//     dhit -> one idle cycle -> dsel=1 with dmemREN. dhit -> pc_wait drops the next cycle.
//  3. Round-robin: after serving channel 0, capture dREN=01 and dWEN=10. Expect channel 1
//     (dmemWEN=1) first, then channel 0.
//  4. dREN=dWEN=1 on channel 0 -> dmemWEN=1 and dmemREN=0.
//     dhit while idle -> no state change.
//  5. TIMEOUT=4: grant issued, no dhit -> timeout_err=1 on the 4th cycle, request still held.
//     Then dhit -> request completes, timeout_err stays 1.
//  6. halt asserted with 2 pending -> DRAIN. Both served, then halted=1 and imemREN=0.
//     A further ihit is ignored. RST mid-DRAIN -> all outputs return to reset values.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and helpers for the request unit and its arbiter
// Contents:
//   ru_state_t : request unit run state (RUN, DRAIN, HALTED)
//   RU_MAX_CH  : largest supported number of data request channels
//   sel_w()    : width of a channel index for n channels, never less than 1
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ru_state_t;

    localparam int RU_MAX_CH = 8;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - signal bundle for the multi-channel request unit
// Ports:
//   CLK : clock shared by both sides
// Modports:
//   ru : the request unit's view (datapath/memory strobes in, requests out)
//   tb : the mirror image, used by whatever drives the unit
interface request_unit_if
    import cpu_types_pkg::*;
#(
    parameter int  NDCH  = 2,
    localparam int SEL_W = sel_w(NDCH)
) (
    input logic CLK
);

    logic             RST;
    logic             iREN;
    logic [NDCH-1:0]  dREN;
    logic [NDCH-1:0]  dWEN;
    logic             ihit;
    logic             dhit;
    logic             halt;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic [SEL_W-1:0] dsel;
    logic             pc_wait;
    logic             halted;
    logic             timeout_err;

    modport ru (
        input  CLK, RST, iREN, dREN, dWEN, ihit, dhit, halt,
        output imemREN, dmemREN, dmemWEN, dsel, pc_wait, halted, timeout_err
    );

    modport tb (
        input  CLK, imemREN, dmemREN, dmemWEN, dsel, pc_wait, halted, timeout_err,
        output RST, iREN, dREN, dWEN, ihit, dhit, halt
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
// Ports:
//   req     : one request bit per requester
//   ptr     : index where the search starts; wraps modulo N
//   gnt_idx : index of the winning requester (0 when none)
//   any     : at least one request is present
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int  N     = 2,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = SEL_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/request_unit_mc.sv
// rtl/request_unit_mc.sv - multi-channel request unit: latches data requests on ihit, serialises them round-robin
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   iREN              : datapath wants an instruction fetch
//   dREN, dWEN        : per-channel data read / write requests, sampled on ihit
//   ihit, dhit        : instruction fetch done / current data access done
//   halt              : datapath halt level
//   imemREN           : instruction read request to memory
//   dmemREN, dmemWEN  : data read / write request for the granted channel
//   dsel              : channel currently granted the data port
//   pc_wait           : data work outstanding, hold the PC
//   halted            : all work drained after halt (sticky)
//   timeout_err       : granted request waited TIMEOUT cycles for dhit (sticky)
module request_unit_mc
    import cpu_types_pkg::*;
#(
    parameter int  NDCH    = 2,
    parameter int  TIMEOUT = 64,
    parameter int  TO_W    = 8,
    localparam int SEL_W   = sel_w(NDCH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  logic [NDCH-1:0]  dREN,
    input  logic [NDCH-1:0]  dWEN,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [SEL_W-1:0] dsel,
    output logic             pc_wait,
    output logic             halted,
    output logic             timeout_err
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    ru_state_t        state;
    logic [NDCH-1:0]  pend;
    logic [NDCH-1:0]  wr;
    logic             gnt_v;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] rr_ptr;
    logic [TO_W-1:0]  wdog;

    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;
    logic             idle;
    logic [SEL_W-1:0] ptr_next;

    rr_arbiter #(.N(NDCH)) u_arb (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign idle     = (pend == '0) && !gnt_v;
    assign ptr_next = (int'(gnt_idx) == NDCH - 1) ? '0 : gnt_idx + SEL_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            pend        <= '0;
            wr          <= '0;
            gnt_v       <= 1'b0;
            gnt_idx     <= '0;
            rr_ptr      <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN:     if (halt) state <= idle ? HALTED : DRAIN;
                DRAIN:   if (idle) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase

            // Capture only when fully idle; halt on the same edge suppresses it.
            // The three branches are mutually exclusive: capture needs pend==0,
            // which also means the arbiter has nothing to grant.
            if (ihit && (state == RUN) && !halt && idle) begin
                pend <= dREN | dWEN;
                wr   <= dWEN;
            end else if (gnt_v && dhit) begin
                pend[gnt_idx] <= 1'b0;
                gnt_v         <= 1'b0;
                rr_ptr        <= ptr_next;
            end else if (!gnt_v && arb_any) begin
                gnt_v   <= 1'b1;
                gnt_idx <= arb_idx;
            end

            // Watchdog counts waiting cycles of a held grant; it only flags, never aborts.
            if (gnt_v && !dhit) begin
                if (wdog < TO_LIM) wdog <= wdog + TO_W'(1);
                if ((TIMEOUT != 0) && (wdog == TO_LIM - TO_W'(1))) timeout_err <= 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end

    assign dmemREN = gnt_v & ~wr[gnt_idx];
    assign dmemWEN = gnt_v &  wr[gnt_idx];
    assign dsel    = gnt_idx;
    assign pc_wait = (pend != '0) | gnt_v;
    assign imemREN = iREN & (state == RUN) & ~pc_wait;
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_request_unit_mc.sv
// tb/tb_request_unit_mc.sv - directed scoreboard bench for request_unit_mc (NDCH=2, TIMEOUT=4)
module tb_request_unit_mc;

    localparam int NDCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    request_unit_if #(.NDCH(NDCH)) bus (.CLK(clk));

    request_unit_mc #(.NDCH(NDCH), .TIMEOUT(4), .TO_W(8)) dut (
        .CLK         (bus.CLK),
        .RST         (bus.RST),
        .iREN        (bus.iREN),
        .dREN        (bus.dREN),
        .dWEN        (bus.dWEN),
        .ihit        (bus.ihit),
        .dhit        (bus.dhit),
        .halt        (bus.halt),
        .imemREN     (bus.imemREN),
        .dmemREN     (bus.dmemREN),
        .dmemWEN     (bus.dmemWEN),
        .dsel        (bus.dsel),
        .pc_wait     (bus.pc_wait),
        .halted      (bus.halted),
        .timeout_err (bus.timeout_err)
    );

    typedef struct {
        int   ch;
        logic we;
    } exp_t;

    exp_t sb[$];
    int   rr_model = 0;
    int   checks   = 0;
    int   errors   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: expected grant order pushed at capture time.
    task automatic capture(input logic [1:0] rd, input logic [1:0] wrv);
        int last;
        last = -1;
        for (int i = 0; i < NDCH; i++) begin
            int c;
            c = (rr_model + i) % NDCH;
            if (rd[c] | wrv[c]) begin
                sb.push_back('{ch: c, we: wrv[c]});
                last = c;
            end
        end
        if (last >= 0) rr_model = (last + 1) % NDCH;
        bus.ihit = 1'b1;
        bus.dREN = rd;
        bus.dWEN = wrv;
        tick();
        bus.ihit = 1'b0;
        bus.dREN = '0;
        bus.dWEN = '0;
    endtask

    task automatic expect_grant(input string tag);
        exp_t e;
        chk({tag, "_busy"}, 32'(bus.dmemREN | bus.dmemWEN), 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed grant expected none queued", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_dsel"}, 32'(bus.dsel), 32'(e.ch));
            chk({tag, "_wen"},  32'(bus.dmemWEN), 32'(e.we));
            chk({tag, "_ren"},  32'(bus.dmemREN), 32'(!e.we));
        end
    endtask

    task automatic do_dhit();
        bus.dhit = 1'b1;
        tick();
        bus.dhit = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ren"},  32'(bus.dmemREN), 32'd0);
        chk({tag, "_wen"},  32'(bus.dmemWEN), 32'd0);
        chk({tag, "_pcw"},  32'(bus.pc_wait), 32'd0);
        chk({tag, "_hlt"},  32'(bus.halted), 32'd0);
        chk({tag, "_dsel"}, 32'(bus.dsel), 32'd0);
        chk({tag, "_to"},   32'(bus.timeout_err), 32'd0);
        chk({tag, "_imem"}, 32'(bus.imemREN), 32'(bus.iREN));
    endtask

    initial begin
        bus.RST  = 1'b1;
        bus.iREN = 1'b1;
        bus.dREN = '0;
        bus.dWEN = '0;
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        bus.halt = 1'b0;

        // 1: reset
        tick();
        tick();
        chk_reset_outputs("rst");
        bus.RST = 1'b0;
        tick();
        chk("t1_imem", 32'(bus.imemREN), 32'd1);
        chk("t1_pcw",  32'(bus.pc_wait), 32'd0);

        // 2: two reads, bubble, ch0 then ch1; stray ihit during a grant is ignored
        capture(2'b11, 2'b00);
        chk("t2_bubble", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
        chk("t2_pcw",    32'(bus.pc_wait), 32'd1);
        chk("t2_imem",   32'(bus.imemREN), 32'd0);
        tick();
        expect_grant("t2_g0");
        bus.ihit = 1'b1;
        bus.dWEN = 2'b01;
        do_dhit();
        bus.ihit = 1'b0;
        bus.dWEN = '0;
        chk("t2_idle",  32'(bus.dmemREN | bus.dmemWEN), 32'd0);
        chk("t2_pcw2",  32'(bus.pc_wait), 32'd1);
        tick();
        expect_grant("t2_g1");
        do_dhit();
        chk("t2_pcw_drop", 32'(bus.pc_wait), 32'd0);
        chk("t2_imem2",    32'(bus.imemREN), 32'd1);
        tick();
        chk("t2_no_stray", 32'(bus.pc_wait), 32'd0);

        // 3: round-robin pointer moves past the served channel
        capture(2'b01, 2'b00);
        tick();
        expect_grant("t3_g0");
        do_dhit();
        capture(2'b01, 2'b10);
        tick();
        expect_grant("t3_g1");
        do_dhit();
        tick();
        expect_grant("t3_g2");
        do_dhit();
        chk("t3_pcw", 32'(bus.pc_wait), 32'd0);

        // 4: read+write on one channel -> write; dhit while idle does nothing
        capture(2'b01, 2'b01);
        tick();
        expect_grant("t4_g0");
        do_dhit();
        do_dhit();
        chk("t4_idle_pcw",  32'(bus.pc_wait), 32'd0);
        chk("t4_idle_busy", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
        chk("t4_idle_imem", 32'(bus.imemREN), 32'd1);

        // 5: watchdog
        capture(2'b10, 2'b00);
        tick();
        expect_grant("t5_g0");
        chk("t5_to_g", 32'(bus.timeout_err), 32'd0);
        tick();
        tick();
        tick();
        chk("t5_to_3", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("t5_to_4",   32'(bus.timeout_err), 32'd1);
        chk("t5_held",   32'(bus.dmemREN), 32'd1);
        chk("t5_dsel",   32'(bus.dsel), 32'd1);
        do_dhit();
        chk("t5_pcw",    32'(bus.pc_wait), 32'd0);
        chk("t5_sticky", 32'(bus.timeout_err), 32'd1);
        chk("t5_sb",     32'(sb.size()), 32'd0);

        // 6: halt with two pending drains, then halts
        capture(2'b11, 2'b00);
        bus.halt = 1'b1;
        tick();
        expect_grant("t6_g0");
        chk("t6_hlt0",  32'(bus.halted), 32'd0);
        chk("t6_imem0", 32'(bus.imemREN), 32'd0);
        do_dhit();
        tick();
        expect_grant("t6_g1");
        do_dhit();
        chk("t6_pcw",   32'(bus.pc_wait), 32'd0);
        chk("t6_hlt1",  32'(bus.halted), 32'd0);
        chk("t6_imem1", 32'(bus.imemREN), 32'd0);
        tick();
        chk("t6_hlt2",  32'(bus.halted), 32'd1);
        chk("t6_imem2", 32'(bus.imemREN), 32'd0);
        bus.ihit = 1'b1;
        bus.dREN = 2'b11;
        tick();
        bus.ihit = 1'b0;
        bus.dREN = '0;
        chk("t6_ign_pcw", 32'(bus.pc_wait), 32'd0);
        tick();
        chk("t6_ign_hlt", 32'(bus.halted), 32'd1);

        // halt and ihit on the same edge: halt wins
        bus.RST  = 1'b1;
        bus.halt = 1'b0;
        tick();
        bus.RST  = 1'b0;
        sb.delete();
        rr_model = 0;
        chk("t6_rst_to", 32'(bus.timeout_err), 32'd0);
        bus.halt = 1'b1;
        bus.ihit = 1'b1;
        bus.dREN = 2'b11;
        tick();
        bus.ihit = 1'b0;
        bus.dREN = '0;
        chk("t6_hi_hlt", 32'(bus.halted), 32'd1);
        chk("t6_hi_pcw", 32'(bus.pc_wait), 32'd0);

        // reset in the middle of a drain
        bus.halt = 1'b0;
        bus.RST  = 1'b1;
        tick();
        bus.RST  = 1'b0;
        capture(2'b10, 2'b00);
        bus.halt = 1'b1;
        tick();
        expect_grant("t6_mid");
        bus.RST  = 1'b1;
        bus.halt = 1'b0;
        tick();
        chk_reset_outputs("t6_midrst");
        bus.RST = 1'b0;
        sb.delete();
        rr_model = 0;
        tick();
        chk("t6_after_pcw",  32'(bus.pc_wait), 32'd0);
        chk("t6_after_busy", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
        chk("t6_after_imem", 32'(bus.imemREN), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
